fir_stream_driver: RTL

//   Upstream/downstream partner of the FIR filter top: buffers host samples, feeds them one at a

---
 rtl/fir_stream_driver.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/fir_stream_driver.sv
// rtl/fir_stream_driver.sv - host-side sample/result buffering and one-at-a-time handshake driver for the FIR filter
module fir_stream_driver #(
  parameter  int WIDTH        = 16,
  parameter  int LENGHT       = 100,
  parameter  int DEPTH        = 8,
  parameter  int TIMEOUT      = 1024,
  localparam int OUTPUT_WIDTH = $clog2(LENGHT) + 2 * WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    smp_wr_en,
  input  logic [WIDTH-1:0]        smp_wr_data,
  output logic                    smp_full,
  input  logic                    res_rd_en,
  output logic [OUTPUT_WIDTH-1:0] res_rd_data,
  output logic                    res_empty,
  output logic [WIDTH-1:0]        fir_input,
  output logic                    fir_input_valid,
  input  logic                    fir_ready,
  input  logic [OUTPUT_WIDTH-1:0] fir_output,
  input  logic                    fir_output_valid,
  output logic                    busy,
  output logic                    err_timeout,
  output logic                    err_spurious,
  input  logic                    err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RES} state_t;

  state_t state, next_state;

  logic [WIDTH-1:0]        smp_mem [DEPTH];
  logic [AW-1:0]           smp_wp, smp_rp;
  logic [CW-1:0]           smp_cnt;
  logic                    smp_empty, smp_push, smp_pop;

  logic [OUTPUT_WIDTH-1:0] res_mem [DEPTH];
  logic [AW-1:0]           res_wp, res_rp;
  logic [CW-1:0]           res_cnt;
  logic                    res_full, res_push_req, res_push, res_pop;

  logic [TW-1:0]           tmo_cnt;
  logic                    tmo_hit, spurious_evt;

  assign smp_empty    = (smp_cnt == '0);
  assign smp_full     = (smp_cnt == CW'(DEPTH));
  assign smp_push     = smp_wr_en && (!smp_full || smp_pop);

  assign res_empty    = (res_cnt == '0);
  assign res_full     = (res_cnt == CW'(DEPTH));
  assign res_pop      = res_rd_en && !res_empty;
  assign res_push     = res_push_req && (!res_full || res_pop);
  assign res_rd_data  = res_empty ? '0 : res_mem[res_rp];

  assign fir_input_valid = (state == ISSUE);
  assign busy            = (state != IDLE);
  assign spurious_evt    = fir_output_valid && (state != WAIT_RES);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Issue is gated on result space so a returning result can never be dropped.
  always_comb begin
    next_state   = state;
    smp_pop      = 1'b0;
    res_push_req = 1'b0;
    tmo_hit      = 1'b0;
    unique case (state)
      IDLE: begin
        if (!smp_empty && !res_full && fir_ready) begin
          smp_pop    = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: next_state = WAIT_RES;
      WAIT_RES: begin
        if (fir_output_valid) begin
          res_push_req = 1'b1;
          next_state   = IDLE;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_hit    = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (smp_push) smp_mem[smp_wp] <= smp_wr_data;
    if (res_push) res_mem[res_wp] <= fir_output;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      smp_wp  <= '0;
      smp_rp  <= '0;
      smp_cnt <= '0;
    end else begin
      if (smp_push) smp_wp <= smp_wp + AW'(1);
      if (smp_pop)  smp_rp <= smp_rp + AW'(1);
      unique case ({smp_push, smp_pop})
        2'b10:   smp_cnt <= smp_cnt + CW'(1);
        2'b01:   smp_cnt <= smp_cnt - CW'(1);
        default: smp_cnt <= smp_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_wp  <= '0;
      res_rp  <= '0;
      res_cnt <= '0;
    end else begin
      if (res_push) res_wp <= res_wp + AW'(1);
      if (res_pop)  res_rp <= res_rp + AW'(1);
      unique case ({res_push, res_pop})
        2'b10:   res_cnt <= res_cnt + CW'(1);
        2'b01:   res_cnt <= res_cnt - CW'(1);
        default: res_cnt <= res_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fir_input <= '0;
      tmo_cnt   <= '0;
    end else begin
      if (smp_pop) fir_input <= smp_mem[smp_rp];
      if (state == ISSUE)         tmo_cnt <= '0;
      else if (state == WAIT_RES) tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  // A new error event in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_timeout  <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      if (tmo_hit)      err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;
      if (spurious_evt) err_spurious <= 1'b1;
      else if (err_clr) err_spurious <= 1'b0;
    end
  end

endmodule
